// File: rtl/mem_access_unit_pkg.sv
// rtl/mem_access_unit_pkg.sv - shared types, funct3 codes and access legality for the memory stage
package mem_access_unit_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } mem_state_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Unsigned variants only exist for loads; stores may only use B/H/W.
   function automatic logic access_legal(
      input logic       rd,
      input logic       wr,
      input logic [2:0] f3,
      input logic [1:0] addr_lo
   );
      logic ok;
      case (f3)
         F3_B:    ok = 1'b1;
         F3_H:    ok = ~addr_lo[0];
         F3_W:    ok = (addr_lo == 2'b00);
         F3_BU:   ok = ~wr;
         F3_HU:   ok = ~wr & ~addr_lo[0];
         default: ok = 1'b0;
      endcase
      return ok & ~(rd & wr);
   endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// rtl/mem_access_unit_load_align.sv - load lane select with sign/zero extension
module load_align
   import mem_access_unit_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  addr,
   input  logic [2:0]  funct3,
   output logic [31:0] result
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   always_comb begin
      byte_lane = rdata[{addr, 3'b000} +: 8];
      half_lane = addr[1] ? rdata[31:16] : rdata[15:0];
      case (funct3)
         F3_B:    result = {{24{byte_lane[7]}}, byte_lane};
         F3_H:    result = {{16{half_lane[15]}}, half_lane};
         F3_W:    result = rdata;
         F3_BU:   result = {24'h000000, byte_lane};
         F3_HU:   result = {16'h0000, half_lane};
         default: result = 32'h0000_0000;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - RV32I memory stage, single outstanding req/ack data access
// Optional WAIT timeout enabled by defining MEM_TIMEOUT_EN.
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ex_valid,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [2:0]  funct3,
   input  logic [31:0] alu_result,
   input  logic [31:0] store_data,
   output logic        stall,
   output logic        wb_valid,
   output logic [31:0] wb_data,
   output logic        access_fault,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_be,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata
);

   mem_state_t  state;
   mem_state_t  state_n;
   logic        request;
   logic        legal;
   logic        accept;
   logic        bad_req;
   logic        expire;
   logic [3:0]  be_n;
   logic [31:0] wdata_n;
   logic [1:0]  addr_lo_q;
   logic [2:0]  funct3_q;
   logic [31:0] load_word;

   assign request = ex_valid & (mem_read | mem_write);
   assign legal   = access_legal(mem_read, mem_write, funct3, alu_result[1:0]);

   always_comb begin
      state_n = state;
      stall   = 1'b0;
      accept  = 1'b0;
      bad_req = 1'b0;
      case (state)
         IDLE: begin
            if (request) begin
               if (legal) begin
                  accept  = 1'b1;
                  stall   = 1'b1;
                  state_n = WAIT;
               end else begin
                  bad_req = 1'b1;
               end
            end
         end
         WAIT: begin
            stall = 1'b1;
            if (dmem_ack) begin
               state_n = DONE;
            end else if (expire) begin
               state_n = IDLE;
            end
         end
         DONE: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

`ifdef MEM_TIMEOUT_EN
   localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

   logic [CW-1:0] tmo_cnt;

   // Ack in the expiry cycle takes priority, so expiry requires no ack.
   assign expire = (state == WAIT) && !dmem_ack && (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tmo_cnt <= '0;
      end else if (accept) begin
         tmo_cnt <= '0;
      end else if ((state == WAIT) && !dmem_ack) begin
         tmo_cnt <= tmo_cnt + 1'b1;
      end
   end
`else
   localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

   assign expire = 1'b0;
`endif

   // Sub-word stores replicate the data across lanes; the byte enables pick the target.
   always_comb begin
      be_n    = 4'b1111;
      wdata_n = 32'h0000_0000;
      if (mem_write) begin
         case (funct3[1:0])
            2'b00: begin
               be_n    = 4'b0001 << alu_result[1:0];
               wdata_n = {4{store_data[7:0]}};
            end
            2'b01: begin
               be_n    = 4'b0011 << {alu_result[1], 1'b0};
               wdata_n = {2{store_data[15:0]}};
            end
            default: begin
               be_n    = 4'b1111;
               wdata_n = store_data;
            end
         endcase
      end
   end

   load_align u_load_align (
      .rdata  (dmem_rdata),
      .addr   (addr_lo_q),
      .funct3 (funct3_q),
      .result (load_word)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dmem_req     <= 1'b0;
         dmem_we      <= 1'b0;
         dmem_addr    <= 32'h0000_0000;
         dmem_wdata   <= 32'h0000_0000;
         dmem_be      <= 4'b0000;
         addr_lo_q    <= 2'b00;
         funct3_q     <= 3'b000;
         wb_data      <= 32'h0000_0000;
         access_fault <= 1'b0;
      end else begin
         access_fault <= bad_req | expire;
         if (accept) begin
            dmem_req   <= 1'b1;
            dmem_we    <= mem_write;
            dmem_addr  <= {alu_result[31:2], 2'b00};
            dmem_wdata <= wdata_n;
            dmem_be    <= be_n;
            addr_lo_q  <= alu_result[1:0];
            funct3_q   <= funct3;
         end else if ((state == WAIT) && (dmem_ack || expire)) begin
            dmem_req <= 1'b0;
         end
         if ((state == WAIT) && dmem_ack) begin
            wb_data <= dmem_we ? 32'h0000_0000 : load_word;
         end
      end
   end

   assign wb_valid = (state == DONE);

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Memory stage of the RV32I pipeline; consumes the execute-stage ALU result as an effective address, together with store data and load/store control. Issues a single outstanding request on a req/ack data-memory port and formats byte/halfword/word accesses. Returns sign- or zero-extended load data to writeback. Stalls the upstream pipeline while an access is in flight.

Parameters:
TIMEOUT_CYCLES, 255, max WAIT cycles before the access is abandoned (used only with MEM_TIMEOUT_EN)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
ex_valid  input  1  execute stage presents a valid instruction
mem_read  input  1  instruction is a load
mem_write  input  1  instruction is a store
funct3  input  3  RV32I size/sign field
alu_result  input  32  effective byte address
store_data  input  32  rs2 value for stores
stall  output  1  upstream must hold its current instruction
wb_valid  output  1  one-cycle pulse: access complete
wb_data  output  32  extended load data; 0 for stores
access_fault  output  1  one-cycle pulse: misaligned, illegal funct3, read&write both set, or timeout
dmem_req  output  1  request, held until ack
dmem_we  output  1  1 = write
dmem_addr  output  32  word address, alu_result with bits [1:0] forced to 0
dmem_wdata  output  32  lane-replicated store data
dmem_be  output  4  byte enables
dmem_ack  input  1  memory accepts/completes in the cycle sampled
dmem_rdata  input  32  read word, valid when dmem_ack=1

Behaviour:
- Reset (async): state IDLE; all outputs 0, except stall, which is combinational and 0 in IDLE with no request.
- FSM states: IDLE, WAIT, DONE.
- IDLE with ex_valid & (mem_read|mem_write) is a request.
- Legal request: latch address, funct3, read/write, dmem_be, dmem_wdata; next state WAIT. stall=1 combinationally in that cycle.
- Faulty request: access_fault pulses on the next edge; no dmem_req; state stays IDLE; stall=0.
- Fault conditions: both read and write set; funct3 not in {000,001,010,100,101} for loads or {000,001,010} for stores; halfword with addr[0]=1; word with addr[1:0]!=0.
- WAIT: dmem_req=1, stall=1. On dmem_ack=1, capture the extended dmem_rdata into wb_data and go to DONE.
- DONE: wb_valid=1 for exactly one cycle, stall=0, then IDLE. DONE never accepts a new request, so the same instruction is not re-issued; the next request is considered in IDLE.
- Minimum latency: request at T0, ack at T1, wb_valid at T2. Each additional wait cycle adds one cycle.
- Byte enables and write data:
  - SB: be=0001<<addr[1:0], wdata={4{byte}}.
  - SH: be=0011<<{addr[1],1'b0}, wdata={2{half}}.
  - SW: be=1111.
  - Loads: be=1111, we=0.
- Load extraction: select the lane by latched addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend.
- wb_data holds its value until the next DONE. Stores complete with wb_data=0.
- dmem_req, dmem_we, dmem_addr, dmem_wdata and dmem_be are registered and stable throughout WAIT.
- Reset mid-WAIT: dmem_req drops asynchronously; any ack arriving after reset is ignored.

Optional Feature:
MEM_TIMEOUT_EN.
- Defined: an 8-bit-minimum counter clears on entering WAIT and increments each WAIT cycle without ack. On reaching TIMEOUT_CYCLES, drop dmem_req, pulse access_fault, return to IDLE, no wb_valid. Ack on the same cycle as expiry wins: normal completion.
- Undefined: no counter; WAIT persists until ack.

Decomposition:
- common package:
  - mem_state_t enum (IDLE, WAIT, DONE).
  - funct3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
- Sub-module load_align: combinational lane select plus sign/zero extension (rdata, addr[1:0], funct3 -> 32-bit result). Instantiated once.

Test Plan:
- LW 0x0000_1000, ack in first WAIT cycle, rdata 0xDEADBEEF -> dmem_addr 0x1000, be 1111, wb_valid at T2, wb_data 0xDEADBEEF, stall high at T0-T1 only.
- LB 0x1003, rdata 0x80123456 -> wb_data 0xFFFFFF80. LBU same -> 0x00000080. LHU 0x1002 -> 0x00008012.
- SH 0x2002, store_data 0x0000_1234 -> dmem_we 1, be 1100, wdata 0x12341234, wb_data 0.
- LW 0x1001 -> access_fault pulse one cycle later, dmem_req never asserted, stall 0. SH 0x2003 and funct3=011 load -> same.
- LW with ack after 3 wait cycles -> dmem_req and stall held 3+1 cycles, outputs stable, single wb_valid. Assert reset in the 2nd wait cycle -> dmem_req 0 immediately, later ack ignored.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> access_fault after 4 WAIT cycles, req dropped, no wb_valid. Ack on the 4th cycle -> normal completion.
